// File: rtl/bus_master_port.sv
// Master-side serial bus port: takes one parallel request, arbitrates,
// serialises start/SID/address, then writes or reads one data word.
// Ports:
//   clk, rstn                        clock, async active-low reset
//   req_valid/req_ready              request handshake
//   req_rd_wrt                       1=write, 0=read
//   req_slave_id/req_addr/req_wdata  request fields
//   rsp_valid/rsp_rdata/rsp_err      one-cycle response
//   arb_req/arb_grant                arbiter handshake
//   bus_util                         high while this port owns the bus
//   data_bus_serial                  shared open bus, pulled high
module bus_master_port #(
    parameter int ADDRESS_WIDTH = 15,
    parameter int DATA_WIDTH    = 8,
    parameter int SID_WIDTH     = 3,
    parameter int TIMEOUT       = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_rd_wrt,
    input  logic [SID_WIDTH-1:0]     req_slave_id,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err,
    output logic                     arb_req,
    input  logic                     arb_grant,
    output logic                     bus_util,
    inout  wire                      data_bus_serial
);

    localparam int SHW  = SID_WIDTH + ADDRESS_WIDTH;
    localparam int CMAX = (ADDRESS_WIDTH > DATA_WIDTH) ?
                          ADDRESS_WIDTH : DATA_WIDTH;
    localparam int CW   = $clog2(CMAX) + 1;
    localparam int TW   = $clog2(TIMEOUT) + 1;

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_MAX  = {TW{1'b1}};

    typedef enum logic [3:0] {
        IDLE,
        ARB_WAIT,
        TX_START,
        TX_SID,
        TX_ADDR,
        WAIT_ADDR_ACK,
        TX_WMARK,
        TX_DATA,
        WAIT_WR_ACK,
        WAIT_RD_START,
        RX_DATA,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  prev0_q, prev0_d;
    logic [SHW-1:0]        sh_q, sh_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic                  drive_en_q, drive_en_d;
    logic                  drive_bit_q, drive_bit_d;
    logic                  arb_req_q, arb_req_d;
    logic                  bus_util_q, bus_util_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic                  bus_lo;
    logic                  tmo_last;
    logic                  go_done;
    logic                  done_err;
    logic [DATA_WIDTH-1:0] done_data;

    assign data_bus_serial = drive_en_q ? drive_bit_q : 1'bz;

    // Z reads as non-zero, so only a real 0 counts as low.
    assign bus_lo   = (data_bus_serial == 1'b0);
    assign tmo_last = (tmo_q == TMO_LAST);

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign arb_req   = arb_req_q;
    assign bus_util  = bus_util_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            prev0_q     <= 1'b0;
            sh_q        <= '0;
            wd_q        <= '0;
            rd_q        <= '0;
            wr_q        <= 1'b0;
            drive_en_q  <= 1'b0;
            drive_bit_q <= 1'b1;
            arb_req_q   <= 1'b0;
            bus_util_q  <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            prev0_q     <= prev0_d;
            sh_q        <= sh_d;
            wd_q        <= wd_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            drive_en_q  <= drive_en_d;
            drive_bit_q <= drive_bit_d;
            arb_req_q   <= arb_req_d;
            bus_util_q  <= bus_util_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
        prev0_d     = bus_lo;
        sh_d        = sh_q;
        wd_d        = wd_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        drive_en_d  = drive_en_q;
        drive_bit_d = drive_bit_q;
        arb_req_d   = arb_req_q;
        bus_util_d  = bus_util_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        go_done     = 1'b0;
        done_err    = 1'b0;
        done_data   = '0;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    wr_d        = req_rd_wrt;
                    sh_d        = {req_slave_id, req_addr};
                    wd_d        = req_wdata;
                    req_ready_d = 1'b0;
                    arb_req_d   = 1'b1;
                    state_d     = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (arb_grant) begin
                    bus_util_d  = 1'b1;
                    drive_en_d  = 1'b1;
                    drive_bit_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = TX_START;
                end
            end
            TX_START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(1)) begin
                    drive_bit_d = sh_q[SHW-1];
                    sh_d        = {sh_q[SHW-2:0], 1'b0};
                    cnt_d       = '0;
                    state_d     = TX_SID;
                end
            end
            TX_SID: begin
                drive_bit_d = sh_q[SHW-1];
                sh_d        = {sh_q[SHW-2:0], 1'b0};
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == CW'(SID_WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = TX_ADDR;
                end
            end
            TX_ADDR: begin
                drive_bit_d = sh_q[SHW-1];
                sh_d        = {sh_q[SHW-2:0], 1'b0};
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == CW'(ADDRESS_WIDTH - 1)) begin
                    drive_en_d = 1'b0;
                    tmo_d      = '0;
                    prev0_d    = 1'b0;
                    state_d    = WAIT_ADDR_ACK;
                end
            end
            WAIT_ADDR_ACK: begin
                // A valid ack on the last allowed cycle still wins.
                if (bus_lo && prev0_q) begin
                    cnt_d = '0;
                    if (wr_q) begin
                        drive_en_d  = 1'b1;
                        drive_bit_d = 1'b0;
                        state_d     = TX_WMARK;
                    end else begin
                        tmo_d   = '0;
                        state_d = WAIT_RD_START;
                    end
                end else if (tmo_last) begin
                    go_done  = 1'b1;
                    done_err = 1'b1;
                end
            end
            TX_WMARK: begin
                cnt_d       = cnt_q + 1'b1;
                drive_bit_d = 1'b1;
                if (cnt_q == CW'(1)) begin
                    drive_bit_d = wd_q[DATA_WIDTH-1];
                    wd_d        = {wd_q[DATA_WIDTH-2:0], 1'b0};
                    cnt_d       = '0;
                    state_d     = TX_DATA;
                end
            end
            TX_DATA: begin
                drive_bit_d = wd_q[DATA_WIDTH-1];
                wd_d        = {wd_q[DATA_WIDTH-2:0], 1'b0};
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                    drive_en_d = 1'b0;
                    tmo_d      = '0;
                    prev0_d    = 1'b0;
                    state_d    = WAIT_WR_ACK;
                end
            end
            WAIT_WR_ACK: begin
                if (!bus_lo && prev0_q) begin
                    go_done = 1'b1;
                end else if (tmo_last) begin
                    go_done  = 1'b1;
                    done_err = 1'b1;
                end
            end
            WAIT_RD_START: begin
                if (bus_lo) begin
                    cnt_d   = '0;
                    state_d = RX_DATA;
                end else if (tmo_last) begin
                    go_done  = 1'b1;
                    done_err = 1'b1;
                end
            end
            RX_DATA: begin
                rd_d  = {rd_q[DATA_WIDTH-2:0], ~bus_lo};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                    go_done   = 1'b1;
                    done_data = rd_d;
                end
            end
            DONE: begin
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Response, bus release and arbiter drop all share one edge.
        if (go_done) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = done_err;
            rsp_rdata_d = done_err ? '0 : done_data;
            drive_en_d  = 1'b0;
            arb_req_d   = 1'b0;
            bus_util_d  = 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_master_port.sv
// Randomised bench for bus_master_port with a frame-level reference model
// and a scripted slave on the pulled-up shared bus.
module tb_bus_master_port;

    localparam int AW = 15;
    localparam int DW = 8;
    localparam int SW = 3;
    localparam int TO = 32;
    localparam int NC = 512;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_rd_wrt = 1'b0;
    logic [SW-1:0] req_slave_id = '0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          arb_req;
    logic          arb_grant = 1'b0;
    logic          bus_util;
    wire           bus;
    logic          slv_en = 1'b0;
    logic          slv_bit = 1'b1;

    pullup (bus);
    assign bus = slv_en ? slv_bit : 1'bz;

    int n_chk = 0;
    int n_fail = 0;

    int          m_exp [NC];
    int          s_exp [NC];
    int          rsp_c;
    logic        exp_err;
    logic [DW-1:0] exp_rd;

    bus_master_port #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH(DW),
        .SID_WIDTH(SW),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_rd_wrt(req_rd_wrt),
        .req_slave_id(req_slave_id),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .arb_req(arb_req),
        .arb_grant(arb_grant),
        .bus_util(bus_util),
        .data_bus_serial(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Cycle 0 is the first TX_START cycle. m_exp: master-driven bit,
    // s_exp: slave-driven bit, -1 where nobody drives (bus reads 1).
    function automatic void build(input logic rw, input logic [SW-1:0] sid,
                                  input logic [AW-1:0] addr,
                                  input logic [DW-1:0] wd, input int ack_d,
                                  input int resp_d, input logic [DW-1:0] rd);
        int wa, m, ww, rs;
        for (int i = 0; i < NC; i++) begin
            m_exp[i] = -1;
            s_exp[i] = -1;
        end
        for (int i = 0; i < 2; i++) m_exp[i] = 0;
        for (int i = 0; i < SW; i++) m_exp[2 + i] = int'(sid[SW-1-i]);
        for (int i = 0; i < AW; i++) m_exp[2 + SW + i] = int'(addr[AW-1-i]);
        wa = 2 + SW + AW;
        exp_err = 1'b1;
        exp_rd = '0;
        if (ack_d >= 0 && ack_d + 1 <= TO - 1) begin
            s_exp[wa + ack_d] = 0;
            s_exp[wa + ack_d + 1] = 0;
            if (rw) begin
                m = wa + ack_d + 2;
                m_exp[m] = 0;
                m_exp[m + 1] = 1;
                for (int i = 0; i < DW; i++) m_exp[m + 2 + i] = int'(wd[DW-1-i]);
                ww = m + 2 + DW;
                if (resp_d >= 0 && resp_d + 1 <= TO - 1) begin
                    s_exp[ww + resp_d] = 0;
                    rsp_c = ww + resp_d + 2;
                    exp_err = 1'b0;
                end else begin
                    if (resp_d >= 0 && resp_d < TO) s_exp[ww + resp_d] = 0;
                    rsp_c = ww + TO;
                end
            end else begin
                rs = wa + ack_d + 2;
                if (resp_d >= 0 && resp_d <= TO - 1) begin
                    s_exp[rs + resp_d] = 0;
                    for (int i = 0; i < DW; i++)
                        s_exp[rs + resp_d + 1 + i] = int'(rd[DW-1-i]);
                    rsp_c = rs + resp_d + 1 + DW;
                    exp_err = 1'b0;
                    exp_rd = rd;
                end else begin
                    rsp_c = rs + TO;
                end
            end
        end else begin
            if (ack_d >= 0 && ack_d < TO) s_exp[wa + ack_d] = 0;
            rsp_c = wa + TO;
        end
    endfunction

    task automatic run_txn(input logic rw, input logic [SW-1:0] sid,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input int gd, input int ack_d, input int resp_d,
                           input logic [DW-1:0] rd, input bit drop,
                           input bit hold, input int abort_c);
        int eb;
        build(rw, sid, addr, wd, ack_d, resp_d, rd);
        req_rd_wrt = rw;
        req_slave_id = sid;
        req_addr = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        chk("ready_idle", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin
            req_valid = 1'b0;
        end else begin
            req_addr = AW'($urandom);
            req_slave_id = SW'($urandom);
            req_wdata = DW'($urandom);
            req_rd_wrt = ~rw;
        end
        chk("ready_busy", req_ready, 0);
        chk("arb_req_up", arb_req, 1);
        for (int i = 0; i < gd; i++) begin
            chk("pre_grant_bus", bus, 1);
            chk("pre_grant_util", bus_util, 0);
            @(negedge clk);
        end
        arb_grant = 1'b1;
        @(negedge clk);
        for (int c = 0; c <= rsp_c; c++) begin
            slv_en = (s_exp[c] >= 0);
            slv_bit = (s_exp[c] != 0);
            #1;
            eb = (m_exp[c] >= 0) ? m_exp[c] : ((s_exp[c] >= 0) ? s_exp[c] : 1);
            chk($sformatf("bus@%0d", c), bus, eb);
            if (c == 0) chk("util_on", bus_util, 1);
            if (c < rsp_c) begin
                chk("no_rsp", rsp_valid, 0);
            end else begin
                chk("rsp_valid", rsp_valid, 1);
                chk("rsp_err", rsp_err, exp_err);
                chk("rsp_rdata", rsp_rdata, exp_rd);
                chk("util_off", bus_util, 0);
                chk("arb_off", arb_req, 0);
                chk("ready_low_at_rsp", req_ready, 0);
            end
            if (drop && c == 10) arb_grant = 1'b0;
            if (c == abort_c) begin
                #2;
                rstn = 1'b0;
                slv_en = 1'b0;
                arb_grant = 1'b0;
                req_valid = 1'b0;
                #1;
                chk("rst_bus", bus, 1);
                chk("rst_util", bus_util, 0);
                chk("rst_arb", arb_req, 0);
                chk("rst_ready", req_ready, 1);
                chk("rst_rsp", rsp_valid, 0);
                repeat (3) @(negedge clk);
                rstn = 1'b1;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        slv_en = 1'b0;
        arb_grant = 1'b0;
        chk("ready_back", req_ready, 1);
        chk("rsp_low", rsp_valid, 0);
        chk("rsp_err_low", rsp_err, 0);
    endtask

    function automatic int rnd_delay();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return -1;
        if (r == 1) return TO - 2;
        if (r == 2) return TO - 1;
        return int'($urandom_range(0, 12));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready0", req_ready, 1);
        chk("rst_rsp0", rsp_valid, 0);
        chk("rst_rdata0", rsp_rdata, 0);
        chk("rst_err0", rsp_err, 0);
        chk("rst_arb0", arb_req, 0);
        chk("rst_util0", bus_util, 0);
        chk("rst_bus0", bus, 1);
        rstn = 1'b1;
        @(negedge clk);

        run_txn(1'b1, 3'b101, 15'h1234, 8'hA5, 0, 0, 0, 8'h00, 0, 0, -1);
        run_txn(1'b0, 3'b010, 15'h7FFF, 8'h00, 0, 0, 10, 8'h3C, 0, 0, -1);
        run_txn(1'b0, 3'b001, 15'h0AAA, 8'h00, 0, -1, 0, 8'h55, 0, 0, -1);
        run_txn(1'b1, 3'b111, 15'h5A5A, 8'hC3, 50, 1, 2, 8'h00, 1, 0, -1);
        run_txn(1'b1, 3'b011, 15'h2222, 8'h99, 0, TO - 2, 0, 8'h00, 0, 0, -1);
        run_txn(1'b1, 3'b011, 15'h2223, 8'h98, 0, TO - 1, 0, 8'h00, 0, 0, -1);
        run_txn(1'b1, 3'b100, 15'h0001, 8'h01, 1, 0, TO - 2, 8'h00, 0, 0, -1);
        run_txn(1'b1, 3'b100, 15'h0002, 8'h02, 1, 0, TO - 1, 8'h00, 0, 0, -1);
        run_txn(1'b0, 3'b110, 15'h4000, 8'h00, 2, 3, TO - 1, 8'hE7, 0, 0, -1);
        run_txn(1'b0, 3'b110, 15'h4001, 8'h00, 2, 3, -1, 8'hE7, 0, 0, -1);
        run_txn(1'b1, 3'b001, 15'h1357, 8'hF0, 0, 0, 0, 8'h00, 0, 0, 2 + SW + AW + 6);
        run_txn(1'b1, 3'b001, 15'h1357, 8'h0F, 0, 0, 1, 8'h00, 0, 0, -1);
        run_txn(1'b0, 3'b010, 15'h0F0F, 8'h00, 0, 2, 4, 8'h81, 0, 1, -1);
        run_txn(1'b1, 3'b101, 15'h7070, 8'h6B, 0, 1, 3, 8'h00, 0, 1, -1);
        run_txn(1'b0, 3'b011, 15'h3333, 8'h00, 0, 0, 0, 8'hB4, 0, 0, -1);

        for (int t = 0; t < 25; t++) begin
            run_txn(1'($urandom), SW'($urandom), AW'($urandom), DW'($urandom),
                    int'($urandom_range(0, 5)), rnd_delay(), rnd_delay(),
                    DW'($urandom), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 3) == 0), -1);
        end
        req_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
- Master-side serial bus port. Accepts one parallel read/write request from a local master (CPU/DMA) and arbitrates for the shared 1-bit bus.
- Serialises start, slave ID and address. Then either serialises write data or deserialises read data, supervising slave acknowledges with timeouts.
- Sits directly upstream of each slave port on data_bus_serial.
- Returns one response (data or error) per request.

Parameters:
ADDRESS_WIDTH, 15, address bits sent per frame
DATA_WIDTH, 8, data bits per transfer
SID_WIDTH, 3, slave ID bits
TIMEOUT, 32, max cycles waited for any slave response (counter width $clog2(TIMEOUT)+1)

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  port idle, request accepted when req_valid&req_ready
req_rd_wrt  input  1  1=write, 0=read
req_slave_id  input  SID_WIDTH  target slave
req_addr  input  ADDRESS_WIDTH  target address
req_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  DATA_WIDTH  read data, valid with rsp_valid on reads
rsp_err  output  1  timeout flag, valid with rsp_valid
arb_req  output  1  bus request to arbiter
arb_grant  input  1  arbiter grant
bus_util  output  1  high while this port owns the bus
data_bus_serial  inout  1  shared open bus, externally pulled high

Behaviour:
- Reset is rstn, asynchronous, active-low; clock is clk. Reset forces IDLE.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, arb_req=0, bus_util=0, bus driver released (Z) immediately, also when reset hits mid-frame.
- Bus drive: drive_en/drive_bit registers; data_bus_serial = drive_en ? drive_bit : Z. Sampled Z/1 counts as 1.
- Accept: in IDLE, req_valid&req_ready latches all req_* fields.
  - req_ready drops next cycle and returns to 1 only in the cycle after rsp_valid.
  - arb_req rises the cycle after accept. Go to ARB_WAIT.
- ARB_WAIT: on sampled arb_grant=1, set bus_util=1 and go to TX_START. No timeout here.
- Once TX_START is entered the frame runs to completion. arb_grant deassertion is ignored.
- TX_START: drive 0 for 2 cycles.
- TX_SID: SID_WIDTH bits, MSB first, 1 cycle each.
- TX_ADDR: ADDRESS_WIDTH bits, MSB first. First address bit is on the bus in cycle 5 after TX_START entry (frame = 2+3+15 = 20 cycles at defaults).
- WAIT_ADDR_ACK:
  - Release bus; clear timeout counter.
  - Success: bus sampled 0 on two consecutive cycles. Go to TX_WMARK (write) or WAIT_RD_START (read).
  - Counter reaches TIMEOUT first: go to DONE with rsp_err=1.
- Write path:
  - TX_WMARK: drive 0 one cycle, then 1 one cycle (slave keys on 0->1).
  - TX_DATA: drive DATA_WIDTH bits MSB first.
  - WAIT_WR_ACK: release bus; wait for sampled 0 then sampled 1 on the next cycle = ack, then go to DONE. TIMEOUT cycles without ack gives rsp_err=1.
- Read path:
  - WAIT_RD_START: bus released; a sampled 0 is the start bit. TIMEOUT exceeded gives rsp_err=1.
  - RX_DATA: sample DATA_WIDTH bits on the following DATA_WIDTH cycles, MSB first, into shift register.
- DONE (1 cycle):
  - rsp_valid=1; rsp_rdata = shift register on read success, otherwise 0.
  - Release bus; arb_req=0 and bus_util=0 on the same edge. Return to IDLE.
- Error: rsp_err=1 only with rsp_valid. Errored read returns rsp_rdata=0. Errored transfer releases the bus exactly like success.
- Timeout counter counts cycles in wait state and saturates. Error asserted when count==TIMEOUT-1 without qualifying event.
- Simultaneous: ack event sampled in the same cycle as the timeout limit counts as success.
- req_valid while busy is ignored (not queued).

Test Plan:
- Write, SID=3'b101, addr=15'h1234, wdata=8'hA5, grant immediate, model slave acks 0,0 then 0->1: bus shows 0,0,1,0,1, then 001001000110100 (MSB first) → ack → marker 0,1 → 10100101; rsp_valid=1, rsp_err=0; bus_util low same edge.
- Read, addr=15'h7FFF, slave returns start 0 then 8'h3C after 10 idle cycles: rsp_rdata=8'h3C, rsp_err=0; req_ready high the cycle after rsp_valid.
- No slave responds after address: rsp_valid with rsp_err=1 exactly TIMEOUT cycles into WAIT_ADDR_ACK; bus released, arb_req=0, rsp_rdata=0.
- Grant delayed 50 cycles, then withdrawn mid-address: no bus activity before grant; frame completes unaffected; single response.
- rstn asserted mid-TX_DATA: data_bus_serial Z, bus_util=0, arb_req=0 asynchronously; next request after release completes normally.
- req_valid held high continuously: exactly one accept per response; second request latched only in IDLE with new field values.
